hamming_encoder_tx: RTL

Upstream transmit stage for the serial Hamming decoder. It accepts 4-bit data nibbles over a valid/ready handshake and buffers them in a small FIFO. Each nibble is encoded into an 8-bit extended Hamming codeword (4 data, 3 parity, 1 overall parity) and shifted out one bit per cycle, LSB first, with a per-bit enable strobe. The codeword format is exactly the one the decoder's syndrome matrix checks.

---
 rtl/hamming_encoder_tx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/hamming_encoder_tx.sv
// hamming_encoder_tx
//
// Transmit stage for the serial extended-Hamming link. Nibbles arrive over a
// valid/ready handshake and are queued in a small circular FIFO. Each queued
// nibble is encoded into an 8-bit codeword {c7,c6,c5,c4,c3,c2,c1,c0} and
// shifted out LSB first, one bit per cycle, with a per-bit enable strobe.
//
// Parameters
//   FIFO_DEPTH : nibble buffer depth, power of two, >= 2
//   GAP_CYCLES : idle cycles (dout_en = 0) between codewords, 0 = back-to-back
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous reset, active low
//   din       : data nibble
//   din_valid : din is valid
//   din_ready : FIFO not full; a transfer happens when din_valid & din_ready
//   dout      : serial codeword bit (registered, 0 when dout_en = 0)
//   dout_en   : dout carries a codeword bit this cycle (registered)
//   busy      : FSM not idle or FIFO non-empty

module hamming_encoder_tx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       dout,
    output logic       dout_en,
    output logic       busy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    // Extended Hamming encoding: c1..c4 carry d[3]..d[0], c0 is even overall parity.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic c1, c2, c3, c4, c5, c6, c7, c0;
        c1 = d[3];
        c2 = d[2];
        c3 = d[1];
        c4 = d[0];
        c5 = c1 ^ c3 ^ c4;
        c6 = c1 ^ c2 ^ c3;
        c7 = c2 ^ c3 ^ c4;
        c0 = c1 ^ c2 ^ c3 ^ c4 ^ c5 ^ c6 ^ c7;
        return {c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    // FIFO storage and bookkeeping
    logic [3:0]      mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            push;
    logic            pop;
    logic [7:0]      head_cw;

    // Serializer state
    state_e          state;
    logic [6:0]      shreg;   // remaining bits cw[7:1], next bit in [0]
    logic [2:0]      bitcnt;
    logic [GapW-1:0] gapcnt;

    assign din_ready = (count != CntW'(FIFO_DEPTH));
    assign push      = din_valid & din_ready;
    assign busy      = (state != StIdle) || (count != '0);
    assign head_cw   = encode(mem[rd_ptr]);

    // A pop is exactly a codeword load; it happens wherever the FSM may start a new word.
    always_comb begin
        pop = 1'b0;
        if (count != '0) begin
            case (state)
                StIdle:  pop = 1'b1;
                StShift: pop = (bitcnt == 3'd7) && (GAP_CYCLES == 0);
                StGap:   pop = (gapcnt == GapW'(1));
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= StIdle;
            shreg   <= '0;
            bitcnt  <= '0;
            gapcnt  <= '0;
            dout    <= 1'b0;
            dout_en <= 1'b0;
        end else if (pop) begin
            state   <= StShift;
            shreg   <= head_cw[7:1];
            dout    <= head_cw[0];
            dout_en <= 1'b1;
            bitcnt  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    dout    <= 1'b0;
                    dout_en <= 1'b0;
                end
                StShift: begin
                    if (bitcnt != 3'd7) begin
                        shreg  <= {1'b0, shreg[6:1]};
                        dout   <= shreg[0];
                        bitcnt <= bitcnt + 3'd1;
                    end else if (GAP_CYCLES > 0) begin
                        state   <= StGap;
                        gapcnt  <= GapW'(GAP_CYCLES);
                        dout    <= 1'b0;
                        dout_en <= 1'b0;
                    end else begin
                        // Last bit sent and nothing queued
                        state   <= StIdle;
                        dout    <= 1'b0;
                        dout_en <= 1'b0;
                    end
                end
                StGap: begin
                    if (gapcnt != GapW'(1)) begin
                        gapcnt <= gapcnt - GapW'(1);
                    end else begin
                        state <= StIdle;
                    end
                    dout    <= 1'b0;
                    dout_en <= 1'b0;
                end
                default: begin
                    state   <= StIdle;
                    dout    <= 1'b0;
                    dout_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
